irq_gateway: RTL and testbench

IRQ_GATEWAY -- requirements
Module: irq_gateway

---
 rtl/irq_gateway_pkg.sv | 16 +
 rtl/irq_gateway_if.sv | 27 ++
 rtl/irq_gateway_source.sv | 45 ++++
 rtl/irq_gateway.sv | 98 +++++++++
 tb/tb_irq_gateway.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/irq_gateway_pkg.sv
// Shared types for the interrupt gateway.
// Source state encoding and the claim-id width helper.
package irq_gateway_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PENDING    = 2'd1,
        IN_SERVICE = 2'd2
    } src_state_e;

    // Claim ids run 1..WIDTH with 0 reserved for "none".
    function automatic int idw_of(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/irq_gateway_if.sv
// Claim/complete handshake bundle between a core and the gateway.
// The core drives requests; the gateway answers claims.
interface irq_gateway_if #(
    parameter int IDW = 1
);
    logic           claim_req;
    logic           claim_valid;
    logic [IDW-1:0] claim_id;
    logic           complete_valid;
    logic [IDW-1:0] complete_id;

    modport master (
        output claim_req,
        output complete_valid,
        output complete_id,
        input  claim_valid,
        input  claim_id
    );

    modport slave (
        input  claim_req,
        input  complete_valid,
        input  complete_id,
        output claim_valid,
        output claim_id
    );
endinterface

// File: rtl/irq_gateway_source.sv
// One interrupt source: IDLE -> PENDING -> IN_SERVICE -> IDLE.
// Pending is latched; a source in service ignores its line and enable.
module irq_gateway_source
    import irq_gateway_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic line,
    input  logic en,
    input  logic grant,
    input  logic complete,
    output logic pending,
    output logic in_service
);

    src_state_e state_q;
    src_state_e state_d;

    // A grant beats a same-cycle disable so the claim response stays true.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (line && en) state_d = PENDING;
            end
            PENDING: begin
                if (grant) state_d = IN_SERVICE;
                else if (!en) state_d = IDLE;
            end
            IN_SERVICE: begin
                if (complete) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    assign pending    = (state_q == PENDING);
    assign in_service = (state_q == IN_SERVICE);

endmodule

// File: rtl/irq_gateway.sv
// Interrupt gateway: per-source FSMs, fixed-priority claim arbiter,
// registered irq, claim response and a wrapping claim counter.
module irq_gateway
    import irq_gateway_pkg::*;
#(
    parameter  int ID    = 0,
    parameter  int WIDTH = 1,
    localparam int IDW   = idw_of(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] interrupts,
    input  logic [WIDTH-1:0] enable,
    output logic             irq,
    input  logic             claim_req,
    output logic             claim_valid,
    output logic [IDW-1:0]   claim_id,
    input  logic             complete_valid,
    input  logic [IDW-1:0]   complete_id,
    output logic [WIDTH-1:0] pending,
    output logic [WIDTH-1:0] in_service,
    output logic [15:0]      claim_count
);

    if (WIDTH < 1 || WIDTH > 31 || ID < 0) begin : g_bad_param
        $error("irq_gateway: illegal WIDTH or ID");
    end

    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] insvc;
    logic [WIDTH-1:0] grant;
    logic [WIDTH-1:0] done;
    logic [IDW-1:0]   win_id;

    logic             irq_q, irq_d;
    logic             claim_valid_q, claim_valid_d;
    logic [IDW-1:0]   claim_id_q, claim_id_d;
    logic [15:0]      claim_count_q, claim_count_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_src
        irq_gateway_source u_src (
            .clock      (clock),
            .reset      (reset),
            .line       (interrupts[i]),
            .en         (enable[i]),
            .grant      (grant[i]),
            .complete   (done[i]),
            .pending    (pend[i]),
            .in_service (insvc[i])
        );
        assign done[i] = complete_valid &&
                         (complete_id == IDW'(i + 1));
    end

    // Scan high to low so the lowest pending index is the last to win.
    always_comb begin
        grant  = '0;
        win_id = '0;
        if (claim_req) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (pend[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    win_id   = IDW'(i + 1);
                end
            end
        end
    end

    always_comb begin
        irq_d         = |(pend & enable);
        claim_valid_d = claim_req;
        claim_id_d    = win_id;
        claim_count_d = claim_count_q + 16'(win_id != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            irq_q         <= 1'b0;
            claim_valid_q <= 1'b0;
            claim_id_q    <= '0;
            claim_count_q <= '0;
        end else begin
            irq_q         <= irq_d;
            claim_valid_q <= claim_valid_d;
            claim_id_q    <= claim_id_d;
            claim_count_q <= claim_count_d;
        end
    end

    assign irq         = irq_q;
    assign claim_valid = claim_valid_q;
    assign claim_id    = claim_id_q;
    assign claim_count = claim_count_q;
    assign pending     = pend;
    assign in_service  = insvc;

endmodule

// File: tb/tb_irq_gateway.sv
// Directed bench for irq_gateway with WIDTH=4.
// Linear stimulus, immediate assertions with hand-computed expectations.
module tb_irq_gateway;

    logic        clk;
    logic        rst;
    logic [3:0]  interrupts;
    logic [3:0]  enable;
    logic        irq;
    logic [3:0]  pending;
    logic [3:0]  in_service;
    logic [15:0] claim_count;

    int vectors = 0;
    int errors  = 0;

    irq_gateway_if #(.IDW(3)) bus ();

    irq_gateway #(.ID(7), .WIDTH(4)) dut (
        .clock          (clk),
        .reset          (rst),
        .interrupts     (interrupts),
        .enable         (enable),
        .irq            (irq),
        .claim_req      (bus.claim_req),
        .claim_valid    (bus.claim_valid),
        .claim_id       (bus.claim_id),
        .complete_valid (bus.complete_valid),
        .complete_id    (bus.complete_id),
        .pending        (pending),
        .in_service     (in_service),
        .claim_count    (claim_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        interrupts         = 4'hF;
        enable             = 4'hF;
        bus.claim_req      = 1'b1;
        bus.complete_valid = 1'b1;
        bus.complete_id    = 3'd1;
        step();
        step();
        // reset holds everything at zero despite active inputs
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_insvc", 32'(in_service), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_cvalid", 32'(bus.claim_valid), 32'h0);
        chk("rst_cid", 32'(bus.claim_id), 32'h0);
        chk("rst_count", 32'(claim_count), 32'h0);

        // single-cycle pulse on source 2, then claim it
        rst                = 1'b0;
        bus.claim_req      = 1'b0;
        bus.complete_valid = 1'b0;
        bus.complete_id    = 3'd0;
        interrupts         = 4'b0100;
        step();
        chk("a_pend", 32'(pending), 32'h4);
        chk("a_irq0", 32'(irq), 32'h0);
        interrupts = 4'b0000;
        step();
        chk("a_pend_held", 32'(pending), 32'h4);
        chk("a_irq1", 32'(irq), 32'h1);
        bus.claim_req = 1'b1;
        step();
        bus.claim_req = 1'b0;
        chk("a_cvalid", 32'(bus.claim_valid), 32'h1);
        chk("a_cid", 32'(bus.claim_id), 32'h3);
        chk("a_insvc", 32'(in_service), 32'h4);
        chk("a_pend_clr", 32'(pending), 32'h0);
        chk("a_count", 32'(claim_count), 32'h1);
        step();
        chk("a_cvalid_off", 32'(bus.claim_valid), 32'h0);
        chk("a_cid_off", 32'(bus.claim_id), 32'h0);
        chk("a_irq_off", 32'(irq), 32'h0);

        // back-to-back claims: 2, 4, then none
        do_reset();
        interrupts = 4'b1010;
        step();
        chk("b_pend", 32'(pending), 32'hA);
        bus.claim_req = 1'b1;
        step();
        chk("b_cid1", 32'(bus.claim_id), 32'h2);
        chk("b_insvc1", 32'(in_service), 32'h2);
        chk("b_pend1", 32'(pending), 32'h8);
        step();
        chk("b_cid2", 32'(bus.claim_id), 32'h4);
        chk("b_insvc2", 32'(in_service), 32'hA);
        chk("b_pend2", 32'(pending), 32'h0);
        step();
        bus.claim_req = 1'b0;
        chk("b_cvalid3", 32'(bus.claim_valid), 32'h1);
        chk("b_cid3", 32'(bus.claim_id), 32'h0);
        chk("b_count", 32'(claim_count), 32'h2);

        // completes for idle / zero / out-of-range ids are ignored
        bus.complete_valid = 1'b1;
        bus.complete_id    = 3'd3;
        step();
        chk("c_bad3", 32'(in_service), 32'hA);
        bus.complete_id = 3'd0;
        step();
        chk("c_bad0", 32'(in_service), 32'hA);
        bus.complete_id = 3'd5;
        step();
        chk("c_bad5", 32'(in_service), 32'hA);
        chk("c_bad_pend", 32'(pending), 32'h0);
        bus.complete_id = 3'd2;
        step();
        bus.complete_valid = 1'b0;
        chk("c_done_insvc", 32'(in_service), 32'h8);
        chk("c_done_idle", 32'(pending), 32'h0);
        step();
        chk("c_repend", 32'(pending), 32'h2);
        step();
        chk("c_irq", 32'(irq), 32'h1);

        // disabling a pending source drops it
        enable = 4'b1101;
        step();
        chk("d_pend", 32'(pending), 32'h0);
        step();
        chk("d_irq", 32'(irq), 32'h0);
        enable     = 4'hF;
        interrupts = 4'h0;

        // same-edge complete of source 1 and claim of source 2
        do_reset();
        interrupts = 4'b0011;
        step();
        chk("e_pend", 32'(pending), 32'h3);
        interrupts    = 4'b0000;
        bus.claim_req = 1'b1;
        step();
        chk("e_cid1", 32'(bus.claim_id), 32'h1);
        chk("e_insvc1", 32'(in_service), 32'h1);
        bus.complete_valid = 1'b1;
        bus.complete_id    = 3'd1;
        step();
        bus.claim_req      = 1'b0;
        bus.complete_valid = 1'b0;
        chk("e_cid2", 32'(bus.claim_id), 32'h2);
        chk("e_insvc2", 32'(in_service), 32'h2);
        chk("e_pend2", 32'(pending), 32'h0);

        // reset right after a claim wipes the response and the count
        do_reset();
        interrupts = 4'b0001;
        step();
        interrupts    = 4'b0000;
        bus.claim_req = 1'b1;
        step();
        bus.claim_req = 1'b0;
        rst           = 1'b1;
        step();
        rst = 1'b0;
        chk("f_cvalid", 32'(bus.claim_valid), 32'h0);
        chk("f_cid", 32'(bus.claim_id), 32'h0);
        chk("f_count", 32'(claim_count), 32'h0);
        chk("f_insvc", 32'(in_service), 32'h0);
        chk("f_irq", 32'(irq), 32'h0);

        // counter wrap: one successful claim every cycle
        do_reset();
        interrupts = 4'hF;
        step();
        bus.claim_req      = 1'b1;
        bus.complete_valid = 1'b1;
        for (int k = 0; k < 65535; k++) begin
            bus.complete_id = bus.claim_id;
            step();
        end
        chk("g_count_max", 32'(claim_count), 32'hFFFF);
        bus.complete_id = bus.claim_id;
        step();
        chk("g_count_wrap", 32'(claim_count), 32'h0);
        bus.claim_req      = 1'b0;
        bus.complete_valid = 1'b0;
        interrupts         = 4'h0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
